// File: rtl/bcd_seq_converter.sv
// rtl/bcd_seq_converter.sv - sequential packed-BCD to binary converter, one digit per clock
module bcd_seq_converter #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      binary_out,
    output logic                  error
);

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [4*DIGITS-1:0]   shreg;
    logic [BIN_W-1:0]      acc;
    logic [CNT_W-1:0]      cnt;

    logic [3:0]            digit;
    logic                  digit_bad;
    logic                  last_digit;
    logic [BIN_W-1:0]      acc_next;

    // The digit under conversion is always the top nibble of the shift register
    assign digit      = shreg[4*DIGITS-1 -: 4];
    assign digit_bad  = (digit > 4'd9);
    assign last_digit = (cnt == '0);
    // acc*10 + d, wrapping at BIN_W bits
    assign acc_next   = (acc << 3) + (acc << 1) + BIN_W'(digit);

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: an invalid digit ends the conversion as early as the last digit does
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CONV;
            CONV:    if (digit_bad || last_digit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, digit accumulation and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg      <= '0;
            acc        <= '0;
            cnt        <= '0;
            binary_out <= '0;
            error      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg <= bcd_in;
                        acc   <= '0;
                        cnt   <= CNT_W'(DIGITS - 1);
                    end
                end
                CONV: begin
                    if (digit_bad) begin
                        binary_out <= '0;
                        error      <= 1'b1;
                    end else begin
                        acc   <= acc_next;
                        shreg <= shreg << 4;
                        if (last_digit) begin
                            binary_out <= acc_next;
                            error      <= 1'b0;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_seq_converter.sv
// tb/tb_bcd_seq_converter.sv - self-checking bench for bcd_seq_converter (DIGITS=4, BIN_W=14)
module tb_bcd_seq_converter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] bcd_in = 16'h0000;
    logic        busy;
    logic        done;
    logic [13:0] binary_out;
    logic        error;

    int n_checks = 0;
    int n_pass   = 0;

    bcd_seq_converter #(.DIGITS(4), .BIN_W(14)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bcd_in     (bcd_in),
        .busy       (busy),
        .done       (done),
        .binary_out (binary_out),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    endtask

    // Reference: decimal value of the operand, 0 if any nibble exceeds 9
    function automatic int ref_val(input logic [15:0] b);
        int v = 0;
        for (int k = 0; k < 4; k++) begin
            if (b[15-4*k -: 4] > 4'd9) return 0;
            v = v * 10 + int'(b[15-4*k -: 4]);
        end
        return v;
    endfunction

    function automatic logic ref_err(input logic [15:0] b);
        for (int k = 0; k < 4; k++)
            if (b[15-4*k -: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    // Digits consumed: up to and including the first invalid one, otherwise all four
    function automatic int ref_lat(input logic [15:0] b);
        for (int k = 0; k < 4; k++)
            if (b[15-4*k -: 4] > 4'd9) return k + 1;
        return 4;
    endfunction

    // Transaction-level model: cycles remaining until idle, and expected held results
    int          m_cnt = 0;
    int          m_val = 0;
    logic        m_err_p = 1'b0;
    int          m_out = 0;
    logic        m_err = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0;
            m_out <= 0;
            m_err <= 1'b0;
        end else if (m_cnt == 0) begin
            if (start) begin
                m_val   <= ref_val(bcd_in);
                m_err_p <= ref_err(bcd_in);
                m_cnt   <= ref_lat(bcd_in) + 1;
            end
        end else begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 2) begin
                m_out <= m_val;
                m_err <= m_err_p;
            end
        end
    end

    // Compare DUT against the model every cycle outside reset
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("busy", 32'(busy), 32'(m_cnt != 0));
            chk("done", 32'(done), 32'(m_cnt == 1));
            chk("binary_out", 32'(binary_out), 32'(m_out));
            chk("error", 32'(error), 32'(m_err));
        end
    end

    // Issue one conversion, scramble bcd_in afterwards, and check latency and result
    task automatic run_conv(input logic [15:0] b, input int exp_val, input logic exp_err, input int exp_lat);
        int  lat;
        logic found;
        @(negedge clk);
        start  = 1'b1;
        bcd_in = b;
        @(negedge clk);
        start  = 1'b0;
        bcd_in = 16'($urandom);
        found = 1'b0;
        lat   = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (done) found = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        chk($sformatf("done_seen_%h", b), 32'(found), 32'd1);
        chk($sformatf("latency_%h", b), 32'(lat), 32'(exp_lat));
        chk($sformatf("result_%h", b), 32'(binary_out), 32'(exp_val));
        chk($sformatf("err_%h", b), 32'(error), 32'(exp_err));
        @(negedge clk);
    endtask

    initial begin
        int n_done;

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_out", 32'(binary_out), 32'd0);
        chk("rst_err", 32'(error), 32'd0);
        rst_n = 1'b1;

        // Pin the reference model to hand-computed values
        chk("ref_1234", 32'(ref_val(16'h1234)), 32'd1234);
        chk("ref_9999", 32'(ref_val(16'h9999)), 32'h270F);
        chk("ref_12a4_val", 32'(ref_val(16'h12A4)), 32'd0);
        chk("ref_12a4_err", 32'(ref_err(16'h12A4)), 32'd1);
        chk("ref_12a4_lat", 32'(ref_lat(16'h12A4)), 32'd3);

        run_conv(16'h1234, 1234, 1'b0, 4);
        run_conv(16'h0000, 0, 1'b0, 4);
        run_conv(16'h9999, 9999, 1'b0, 4);
        run_conv(16'h12A4, 0, 1'b1, 3);
        run_conv(16'h0042, 42, 1'b0, 4);
        run_conv(16'hF000, 0, 1'b1, 1);
        run_conv(16'h0807, 807, 1'b0, 4);

        // Start pulsed at E2 of a running conversion must be ignored
        @(negedge clk);
        start = 1'b1; bcd_in = 16'h1234;
        @(negedge clk);
        start = 1'b0; bcd_in = 16'h9999;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        chk("busy_start_dones", 32'(n_done), 32'd1);
        chk("busy_start_result", 32'(binary_out), 32'h04D2);

        // Reset dropped at E2 abandons the conversion at once
        @(negedge clk);
        start = 1'b1; bcd_in = 16'h1234;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_out", 32'(binary_out), 32'd0);
        chk("midrst_err", 32'(error), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("midrst_no_done", 32'(n_done), 32'd0);
        run_conv(16'h0507, 507, 1'b0, 4);

        // start held high: back-to-back conversions
        @(negedge clk);
        start = 1'b1; bcd_in = 16'h0042;
        n_done = 0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        start = 1'b0;
        chk("b2b_dones", 32'(n_done), 32'd3);
        repeat (8) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
